seg_scan_controller: RTL and testbench

SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

---
 rtl/seg_scan_controller.sv | 187 ++++++++++++++++++
 tb/tb_seg_scan_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Multiplexed 4-digit seven-segment scanner with a shadow/active register pair committed at frame boundaries.
// Latency: registered outputs; a committed value appears at the first SHOW slot of the frame after its boundary.
// Backpressure: none; dataValid is accepted every cycle, and the last write before a boundary wins.
module seg_scan_controller #(
    parameter int TICKS_PER_DIGIT    = 8192,
    parameter int BLANK_TICKS        = 256,
    parameter bit SEGMENT_ACTIVE_LOW = 1'b1,
    parameter bit DIGIT_ACTIVE_LOW   = 1'b1
) (
    input  logic        clock,
    input  logic        notReset,
    input  logic        enable,
    input  logic [15:0] data,
    input  logic [3:0]  dpMask,
    input  logic        dataValid,
    output logic [7:0]  segment,
    output logic [3:0]  digit,
    output logic        frameDone,
    output logic        pending
);

    // Slot counter runs 0..TICKS_PER_DIGIT-1 across BLANK then SHOW of one digit slot.
    localparam int              CW         = $clog2(TICKS_PER_DIGIT);
    localparam logic [CW-1:0]   LAST_TICK  = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [CW-1:0]   LAST_BLANK = CW'(BLANK_TICKS - 1);
    localparam logic [7:0]      SEG_DARK   = SEGMENT_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0]      DIG_DARK   = DIGIT_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        state;
    state_t        nxt_state;
    logic [1:0]    index;
    logic [1:0]    nxt_index;
    logic [CW-1:0] count;
    logic [CW-1:0] nxt_count;
    logic          boundary;

    logic [15:0]   shadow_data;
    logic [3:0]    shadow_dp;
    logic [15:0]   active_data;
    logic [3:0]    active_dp;

    logic [3:0]    show_nib;
    logic          show_dp;
    logic [7:0]    seg_raw;
    logic [7:0]    seg_show;
    logic [3:0]    dig_raw;
    logic [3:0]    dig_show;

    // Active-high g..a pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_decode = 7'h3F;
            4'h1:    hex_decode = 7'h06;
            4'h2:    hex_decode = 7'h5B;
            4'h3:    hex_decode = 7'h4F;
            4'h4:    hex_decode = 7'h66;
            4'h5:    hex_decode = 7'h6D;
            4'h6:    hex_decode = 7'h7D;
            4'h7:    hex_decode = 7'h07;
            4'h8:    hex_decode = 7'h7F;
            4'h9:    hex_decode = 7'h6F;
            4'hA:    hex_decode = 7'h77;
            4'hB:    hex_decode = 7'h7C;
            4'hC:    hex_decode = 7'h39;
            4'hD:    hex_decode = 7'h5E;
            4'hE:    hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    // Next state, digit index and slot count; flags the edge that opens a new frame.
    always_comb begin
        nxt_state = state;
        nxt_index = index;
        nxt_count = count;
        boundary  = 1'b0;
        if (!enable) begin
            nxt_state = IDLE;
            nxt_index = 2'd0;
            nxt_count = '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt_state = BLANK;
                    nxt_index = 2'd0;
                    nxt_count = '0;
                    boundary  = 1'b1;
                end
                BLANK: begin
                    nxt_count = count + 1'b1;
                    if (count == LAST_BLANK) begin
                        nxt_state = SHOW;
                    end
                end
                SHOW: begin
                    if (count == LAST_TICK) begin
                        nxt_state = BLANK;
                        nxt_count = '0;
                        nxt_index = index + 2'd1;
                        boundary  = (index == 2'd3);
                    end else begin
                        nxt_count = count + 1'b1;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_index = 2'd0;
                    nxt_count = '0;
                end
            endcase
        end
    end

    // Pattern for the digit about to be shown, taken only from the active register.
    always_comb begin
        case (nxt_index)
            2'd0:    show_nib = active_data[15:12];
            2'd1:    show_nib = active_data[11:8];
            2'd2:    show_nib = active_data[7:4];
            default: show_nib = active_data[3:0];
        endcase
        show_dp  = active_dp[nxt_index];
        seg_raw  = {show_dp, hex_decode(show_nib)};
        seg_show = SEGMENT_ACTIVE_LOW ? ~seg_raw : seg_raw;
        dig_raw  = 4'b0001 << nxt_index;
        dig_show = DIGIT_ACTIVE_LOW ? ~dig_raw : dig_raw;
    end

    // Scan FSM with registered outputs; outputs follow the state being entered on the same edge.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state     <= IDLE;
            index     <= 2'd0;
            count     <= '0;
            frameDone <= 1'b0;
            segment   <= SEG_DARK;
            digit     <= DIG_DARK;
        end else begin
            state     <= nxt_state;
            index     <= nxt_index;
            count     <= nxt_count;
            frameDone <= boundary;
            if (nxt_state == SHOW) begin
                segment <= seg_show;
                digit   <= dig_show;
            end else begin
                segment <= SEG_DARK;
                digit   <= DIG_DARK;
            end
        end
    end

    // Shadow capture and frame-boundary commit; a write on the boundary edge bypasses the shadow.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            shadow_data <= 16'h0000;
            shadow_dp   <= 4'h0;
            active_data <= 16'h0000;
            active_dp   <= 4'h0;
            pending     <= 1'b0;
        end else begin
            if (dataValid) begin
                shadow_data <= data;
                shadow_dp   <= dpMask;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (dataValid) begin
                    active_data <= data;
                    active_dp   <= dpMask;
                end else if (pending) begin
                    active_data <= shadow_data;
                    active_dp   <= shadow_dp;
                end
            end else if (dataValid) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller with an 8-tick slot and 2-tick blanking.
// Latency: expected {frameDone,digit,segment} per edge are queued before the edge and compared 1 time unit after it.
// Backpressure: none; stimulus is driven on the falling edge.
module tb_seg_scan_controller;

    localparam int TPD = 8;
    localparam int BT  = 2;

    logic        clock;
    logic        notReset;
    logic        enable;
    logic [15:0] data;
    logic [3:0]  dpMask;
    logic        dataValid;
    logic [7:0]  segment;
    logic [3:0]  digit;
    logic        frameDone;
    logic        pending;

    int checks;
    int fails;

    logic [12:0] exp_q[$];

    seg_scan_controller #(
        .TICKS_PER_DIGIT    (TPD),
        .BLANK_TICKS        (BT),
        .SEGMENT_ACTIVE_LOW (1'b1),
        .DIGIT_ACTIVE_LOW   (1'b1)
    ) dut (
        .clock     (clock),
        .notReset  (notReset),
        .enable    (enable),
        .data      (data),
        .dpMask    (dpMask),
        .dataValid (dataValid),
        .segment   (segment),
        .digit     (digit),
        .frameDone (frameDone),
        .pending   (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference glyph table, active-high g..a.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[nib];
    endfunction

    // Queue the 32 expected output samples of one full frame showing d with decimal points dp.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp);
        logic [3:0] nib;
        logic [7:0] seg;
        logic [3:0] dig;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < TPD; c++) begin
                if (c < BT) begin
                    exp_q.push_back({(s == 0 && c == 0), 4'hF, 8'hFF});
                end else begin
                    nib = d[15 - 4 * s -: 4];
                    seg = ~{dp[s], glyph(nib)};
                    dig = ~(4'b0001 << s);
                    exp_q.push_back({1'b0, dig, seg});
                end
            end
        end
    endtask

    // Scoreboard: every edge with a queued expectation is compared just after the edge.
    always @(posedge clock) begin
        logic [12:0] e;
        logic [12:0] obs;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = {frameDone, digit, segment};
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL scan t=%0t {fd,digit,seg} got %h expected %h", $time, obs, e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        notReset  = 1'b0;
        enable    = 1'b0;
        data      = 16'h0000;
        dpMask    = 4'h0;
        dataValid = 1'b0;
        tick(3);
        checks++; if (segment !== 8'hFF) begin fails++; $display("FAIL reset_segment got %h expected ff", segment); end
        checks++; if (digit !== 4'hF) begin fails++; $display("FAIL reset_digit got %h expected f", digit); end
        checks++; if (frameDone !== 1'b0) begin fails++; $display("FAIL reset_frameDone got %b expected 0", frameDone); end
        checks++; if (pending !== 1'b0) begin fails++; $display("FAIL reset_pending got %b expected 0", pending); end
    endtask

    task automatic test_basic_scan;
        notReset  = 1'b1;
        data      = 16'h1234;
        dpMask    = 4'h0;
        dataValid = 1'b1;
        tick(1);
        dataValid = 1'b0;
        checks++; if (pending !== 1'b1) begin fails++; $display("FAIL idle_write_pending got %b expected 1", pending); end
        checks++; if (digit !== 4'hF) begin fails++; $display("FAIL idle_dark_digit got %h expected f", digit); end
        enable = 1'b1;
        push_frame(16'h1234, 4'h0);
        push_frame(16'h1234, 4'h0);
        tick(2 * 4 * TPD);
        checks++; if (pending !== 1'b0) begin fails++; $display("FAIL basic_pending got %b expected 0", pending); end
    endtask

    task automatic test_midframe_write;
        push_frame(16'h1234, 4'h0);
        tick(10);
        data      = 16'hABCD;
        dataValid = 1'b1;
        tick(1);
        dataValid = 1'b0;
        checks++; if (pending !== 1'b1) begin fails++; $display("FAIL mid_pending_set got %b expected 1", pending); end
        tick(21);
        checks++; if (pending !== 1'b1) begin fails++; $display("FAIL mid_pending_hold got %b expected 1", pending); end
        push_frame(16'hABCD, 4'h0);
        tick(1);
        checks++; if (pending !== 1'b0) begin fails++; $display("FAIL mid_pending_clear got %b expected 0", pending); end
        tick(31);
    endtask

    task automatic test_boundary_write;
        data      = 16'h8888;
        dataValid = 1'b1;
        push_frame(16'h8888, 4'h0);
        tick(1);
        dataValid = 1'b0;
        checks++; if (pending !== 1'b0) begin fails++; $display("FAIL boundary_pending got %b expected 0", pending); end
        tick(31);
    endtask

    task automatic test_back_to_back;
        push_frame(16'h8888, 4'h0);
        tick(5);
        data      = 16'h1111;
        dataValid = 1'b1;
        tick(1);
        dataValid = 1'b0;
        tick(10);
        data      = 16'h2222;
        dataValid = 1'b1;
        tick(1);
        dataValid = 1'b0;
        tick(15);
        checks++; if (pending !== 1'b1) begin fails++; $display("FAIL b2b_pending got %b expected 1", pending); end
        push_frame(16'h2222, 4'h0);
        tick(32);
    endtask

    task automatic test_disable;
        push_frame(16'h2222, 4'h0);
        repeat (12) void'(exp_q.pop_back());
        tick(20);
        enable = 1'b0;
        tick(1);
        checks++; if (digit !== 4'hF) begin fails++; $display("FAIL disable_digit got %h expected f", digit); end
        checks++; if (segment !== 8'hFF) begin fails++; $display("FAIL disable_segment got %h expected ff", segment); end
        checks++; if (frameDone !== 1'b0) begin fails++; $display("FAIL disable_frameDone got %b expected 0", frameDone); end
        tick(1);
        checks++; if (digit !== 4'hF) begin fails++; $display("FAIL idle_hold_digit got %h expected f", digit); end
        enable = 1'b1;
        push_frame(16'h2222, 4'h0);
        tick(32);
    endtask

    task automatic test_async_reset;
        data      = 16'h9000;
        dpMask    = 4'b0001;
        dataValid = 1'b1;
        push_frame(16'h9000, 4'b0001);
        repeat (27) void'(exp_q.pop_back());
        tick(1);
        dataValid = 1'b0;
        tick(4);
        checks++; if (segment !== 8'h10) begin fails++; $display("FAIL pre_reset_segment got %h expected 10", segment); end
        notReset = 1'b0;
        #1;
        checks++; if (segment !== 8'hFF) begin fails++; $display("FAIL async_segment got %h expected ff", segment); end
        checks++; if (digit !== 4'hF) begin fails++; $display("FAIL async_digit got %h expected f", digit); end
        checks++; if (frameDone !== 1'b0) begin fails++; $display("FAIL async_frameDone got %b expected 0", frameDone); end
        checks++; if (pending !== 1'b0) begin fails++; $display("FAIL async_pending got %b expected 0", pending); end
        tick(2);
        data     = 16'hFFFF;
        dpMask   = 4'hF;
        notReset = 1'b1;
        push_frame(16'h0000, 4'h0);
        tick(32);
        checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL queue_drained got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_basic_scan();
        test_midframe_write();
        test_boundary_write();
        test_back_to_back();
        test_disable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
